// File: rtl/audio_pkg.sv
// Shared definitions for the audio capture path.
//   - state_e     : recorder FSM states
//   - DATA_W_DEF  : default sample width (codec set to 16-bit I2S)
//   - ADDR_W_DEF  : default SRAM word address width
//   - I2S_DELAY   : MSB arrives this many BCLK cycles after the LRC falling edge
//   - CNT_W       : width of the deserialiser bit counter
package audio_pkg;

  localparam int DATA_W_DEF = 16;
  localparam int ADDR_W_DEF = 20;
  localparam int I2S_DELAY  = 1;
  localparam int CNT_W      = 5;

  typedef enum logic [2:0] {
    S_IDLE,
    S_WAIT_LEFT,
    S_SHIFT,
    S_STORE,
    S_WAIT_RIGHT,
    S_PAUSE
  } state_e;

endpackage

// File: rtl/i2s_deser.sv
// I2S left-channel front end: LRC falling-edge detector plus MSB-first shifter.
//   i_clk        : codec BCLK, rising edge
//   i_rst_n      : asynchronous active-low reset
//   i_lrc        : codec ADCLRCK (low = left channel)
//   i_data       : codec ADCDAT serial bit
//   i_shift_en   : shift one bit in this cycle (owner FSM is in S_SHIFT)
//   o_lrc_fall   : i_lrc low now and high on the previous cycle
//   o_word       : assembled word, holds while not shifting
//   o_word_done  : the bit shifted in this cycle is the last of the word
module i2s_deser
  import audio_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_lrc,
  input  logic              i_data,
  input  logic              i_shift_en,
  output logic              o_lrc_fall,
  output logic [DATA_W-1:0] o_word,
  output logic              o_word_done
);

  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_W - 1);

  logic              lrc_q;
  logic [CNT_W-1:0]  cnt_q;
  logic [DATA_W-1:0] shift_q;

  // lrc_q resets high so an LRC already low out of reset reads as a falling
  // edge; the FSM is idle at that point and ignores it.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      lrc_q   <= 1'b1;
      cnt_q   <= '0;
      shift_q <= '0;
    end else begin
      // NOTE: state registers use non-blocking assignments so every register
      // samples pre-edge values, independent of statement order.
      lrc_q <= i_lrc;
      if (i_shift_en) begin
        shift_q <= {shift_q[DATA_W-2:0], i_data};
        cnt_q   <= o_word_done ? '0 : cnt_q + 1'b1;
      end else begin
        // An aborted partial word leaves no stale count for the next frame.
        cnt_q <= '0;
      end
    end
  end

  assign o_lrc_fall  = ~i_lrc & lrc_q;
  assign o_word_done = i_shift_en && (cnt_q == LAST_BIT);
  assign o_word      = shift_q;

endmodule

// File: rtl/aud_recorder.sv
// WM8731 ADC capture stage: records left-channel I2S samples into SRAM.
//   i_clk     : codec BCLK, all logic on rising edge
//   i_rst_n   : asynchronous active-low reset
//   i_start   : start recording (from idle) or resume (from pause)
//   i_pause   : pause once the sample in flight is stored
//   i_stop    : abort, back to idle next cycle
//   i_lrc     : codec ADCLRCK, low = left channel
//   i_data    : codec ADCDAT
//   o_address : SRAM address of the current/last write
//   o_data    : captured sample, valid with o_valid and held afterwards
//   o_valid   : one-cycle SRAM write strobe
//   o_length  : samples written in this take
//   o_full    : sticky, last SRAM address has been written
//   o_busy    : FSM is not idle
module aud_recorder
  import audio_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int ADDR_W = ADDR_W_DEF
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_start,
  input  logic              i_pause,
  input  logic              i_stop,
  input  logic              i_lrc,
  input  logic              i_data,
  output logic [ADDR_W-1:0] o_address,
  output logic [DATA_W-1:0] o_data,
  output logic              o_valid,
  output logic [ADDR_W-1:0] o_length,
  output logic              o_full,
  output logic              o_busy
);

  localparam logic [ADDR_W-1:0] ADDR_MAX = '1;

  state_e            state_q;
  logic [ADDR_W-1:0] addr_q;
  logic [ADDR_W-1:0] len_q;
  logic [DATA_W-1:0] data_q;
  logic              valid_q;
  logic              full_q;
  logic              busy_q;
  logic              pause_pend_q;

  logic              lrc_fall;
  logic              word_done;
  logic [DATA_W-1:0] word;
  logic              shift_en;

  assign shift_en = (state_q == S_SHIFT);

  i2s_deser #(
    .DATA_W (DATA_W)
  ) u_deser (
    .i_clk       (i_clk),
    .i_rst_n     (i_rst_n),
    .i_lrc       (i_lrc),
    .i_data      (i_data),
    .i_shift_en  (shift_en),
    .o_lrc_fall  (lrc_fall),
    .o_word      (word),
    .o_word_done (word_done)
  );

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q      <= S_IDLE;
      addr_q       <= '0;
      len_q        <= '0;
      data_q       <= '0;
      valid_q      <= 1'b0;
      full_q       <= 1'b0;
      busy_q       <= 1'b0;
      pause_pend_q <= 1'b0;
    end else begin
      valid_q <= 1'b0;

      // Bookkeeping runs the cycle after the strobe, whatever state follows,
      // so o_address still names the written word while o_valid is high.
      // o_length saturates: with a full memory it cannot represent 2**ADDR_W.
      if (valid_q) begin
        if (len_q != ADDR_MAX) len_q <= len_q + 1'b1;
        if (addr_q == ADDR_MAX) full_q <= 1'b1;
        else                    addr_q <= addr_q + 1'b1;
      end

      unique case (state_q)
        S_IDLE: begin
          // Written after the bookkeeping so a new take clears it.
          if (i_start && !i_stop) begin
            addr_q  <= '0;
            len_q   <= '0;
            full_q  <= 1'b0;
            busy_q  <= 1'b1;
            state_q <= S_WAIT_LEFT;
          end
        end
        S_WAIT_LEFT: begin
          if (i_stop) begin
            busy_q  <= 1'b0;
            state_q <= S_IDLE;
          end else if (i_pause) begin
            state_q <= S_PAUSE;
          end else if (lrc_fall) begin
            state_q <= S_SHIFT;
          end
        end
        S_SHIFT: begin
          // A pause seen mid-word is remembered and honoured after the store.
          if (i_pause) pause_pend_q <= 1'b1;
          if (i_stop) begin
            pause_pend_q <= 1'b0;
            busy_q       <= 1'b0;
            state_q      <= S_IDLE;
          end else if (word_done) begin
            state_q <= S_STORE;
          end
        end
        S_STORE: begin
          valid_q      <= 1'b1;
          data_q       <= word;
          pause_pend_q <= 1'b0;
          if (i_stop || addr_q == ADDR_MAX) begin
            busy_q  <= 1'b0;
            state_q <= S_IDLE;
          end else if (i_pause || pause_pend_q) begin
            state_q <= S_PAUSE;
          end else begin
            state_q <= S_WAIT_RIGHT;
          end
        end
        S_WAIT_RIGHT: begin
          if (i_stop) begin
            busy_q  <= 1'b0;
            state_q <= S_IDLE;
          end else if (i_pause) begin
            state_q <= S_PAUSE;
          end else if (i_lrc) begin
            state_q <= S_WAIT_LEFT;
          end
        end
        S_PAUSE: begin
          // Resume via S_WAIT_RIGHT so a half-elapsed left slot is skipped.
          if (i_stop) begin
            busy_q  <= 1'b0;
            state_q <= S_IDLE;
          end else if (i_start && !i_pause) begin
            state_q <= S_WAIT_RIGHT;
          end
        end
        default: begin
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign o_address = addr_q;
  assign o_data    = data_q;
  assign o_valid   = valid_q;
  assign o_length  = len_q;
  assign o_full    = full_q;
  assign o_busy    = busy_q;

endmodule

// File: tb/tb_aud_recorder.sv
// Scoreboard bench for aud_recorder. A default-size instance covers the
// record / pause / stop / reset sequences; a 3-bit-address instance covers
// the memory-full boundary. Both share the codec serial lines.
module tb_aud_recorder;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n, start, pause, stop, lrc, sdata, start_s;

  logic [19:0] m_addr, m_len;
  logic [15:0] m_data;
  logic        m_valid, m_full, m_busy;

  logic [2:0]  s_addr, s_len;
  logic [15:0] s_data;
  logic        s_valid, s_full, s_busy;

  aud_recorder dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_start(start), .i_pause(pause),
    .i_stop(stop), .i_lrc(lrc), .i_data(sdata),
    .o_address(m_addr), .o_data(m_data), .o_valid(m_valid),
    .o_length(m_len), .o_full(m_full), .o_busy(m_busy)
  );

  aud_recorder #(.DATA_W(16), .ADDR_W(3)) dut_small (
    .i_clk(clk), .i_rst_n(rst_n), .i_start(start_s), .i_pause(1'b0),
    .i_stop(1'b0), .i_lrc(lrc), .i_data(sdata),
    .o_address(s_addr), .o_data(s_data), .o_valid(s_valid),
    .o_length(s_len), .o_full(s_full), .o_busy(s_busy)
  );

  typedef struct {
    logic [15:0] data;
    int          addr;
    int          cyc;
  } exp_t;

  exp_t q_m[$];
  exp_t q_s[$];
  int   total = 0;
  int   bad   = 0;
  int   cycle_cnt = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: samples 1 time unit after each rising edge; cycle_cnt is the
  // index of the edge just taken.
  exp_t em, es;
  always @(posedge clk) begin
    #1;
    cycle_cnt++;
    if (m_valid) begin
      if (q_m.size() == 0) begin
        total++; bad++;
        $display("FAIL m_unexpected_strobe: data %0h addr %0h at cycle %0d", m_data, m_addr, cycle_cnt);
      end else begin
        em = q_m.pop_front();
        check("m_data", m_data, em.data);
        check("m_addr", m_addr, em.addr);
        check("m_cycle", cycle_cnt, em.cyc);
      end
    end
    if (s_valid) begin
      if (q_s.size() == 0) begin
        total++; bad++;
        $display("FAIL s_unexpected_strobe: data %0h addr %0h at cycle %0d", s_data, s_addr, cycle_cnt);
      end else begin
        es = q_s.pop_front();
        check("s_data", s_data, es.data);
        check("s_addr", s_addr, es.addr);
        check("s_cycle", cycle_cnt, es.cyc);
      end
    end
  end

  // One BCLK period of codec and command inputs, applied on the falling edge.
  task automatic slot(input logic l, input logic d, input logic st, input logic pa, input logic sp);
    @(negedge clk);
    lrc = l; sdata = d; start = st; pause = pa; stop = sp;
  endtask

  task automatic pulse_start();
    slot(1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
    slot(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  // One 40-cycle LRC frame: 20 cycles left (falling edge at slot 0, MSB at
  // slot 1) then 20 cycles right. ea_m/ea_s give the expected write address
  // of the left word for each instance, -1 for no capture. pause_at/stop_at/
  // rst_at place a one-cycle command at that slot, -1 for none.
  task automatic send_frame(input logic [15:0] lw, input logic [15:0] rw,
                            input int ea_m, input int ea_s,
                            input int pause_at, input int stop_at, input int rst_at);
    logic d;
    int   t;
    for (int k = 0; k < 40; k++) begin
      d = 1'b0;
      if (k >= 1 && k <= 16)       d = lw[16-k];
      else if (k >= 21 && k <= 36) d = rw[36-k];
      slot((k < 20) ? 1'b0 : 1'b1, d, 1'b0, (k == pause_at), (k == stop_at));
      if (k == 0) begin
        t = cycle_cnt + 1;
        if (ea_m >= 0) q_m.push_back('{data: lw, addr: ea_m, cyc: t + 17});
        if (ea_s >= 0) q_s.push_back('{data: lw, addr: ea_s, cyc: t + 17});
      end
      if (stop_at >= 0 && k == stop_at + 1) check("stop_busy_next_cycle", m_busy, 0);
      if (k == rst_at) begin
        #2 rst_n = 1'b0;
        #1;
        check("rst_mid_addr",  m_addr,  0);
        check("rst_mid_len",   m_len,   0);
        check("rst_mid_data",  m_data,  0);
        check("rst_mid_valid", m_valid, 0);
        check("rst_mid_busy",  m_busy,  0);
      end
      if (rst_at >= 0 && k == rst_at + 1) rst_n = 1'b1;
    end
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; pause = 1'b0; stop = 1'b0;
    lrc = 1'b1; sdata = 1'b0; start_s = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_addr",  m_addr,  0);
    check("reset_data",  m_data,  0);
    check("reset_valid", m_valid, 0);
    check("reset_len",   m_len,   0);
    check("reset_full",  m_full,  0);
    check("reset_busy",  m_busy,  0);
    check("reset_s_len", s_len,   0);
    check("reset_s_busy", s_busy, 0);
    rst_n = 1'b1;
    repeat (2) slot(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);

    // Two words, right channel all ones never captured.
    pulse_start();
    send_frame(16'hA5C3, 16'hFFFF, 0, -1, -1, -1, -1);
    send_frame(16'h1234, 16'hFFFF, 1, -1, -1, -1, -1);
    check("two_words_len",  m_len,  2);
    check("two_words_addr", m_addr, 2);
    check("two_words_busy", m_busy, 1);

    // Pause mid-word: the word still lands, then nothing until resume.
    send_frame(16'hBEEF, 16'hFFFF, 2, -1, 8, -1, -1);
    send_frame(16'h1111, 16'hFFFF, -1, -1, -1, -1, -1);
    check("paused_len",  m_len,  3);
    check("paused_addr", m_addr, 3);
    check("paused_busy", m_busy, 1);
    pulse_start();
    send_frame(16'h2222, 16'h0000, 3, -1, -1, -1, -1);
    check("resumed_len", m_len, 4);

    // Stop mid-word: partial word dropped, counters hold.
    send_frame(16'h3333, 16'hFFFF, -1, -1, -1, 10, -1);
    check("stopped_len",  m_len,  4);
    check("stopped_addr", m_addr, 4);
    check("stopped_busy", m_busy, 0);

    // Start while the left slot is already under way: that slot is skipped.
    for (int k = 0; k < 5; k++) slot(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    slot(1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
    for (int k = 0; k < 14; k++) slot(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    for (int k = 0; k < 20; k++) slot(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    send_frame(16'h5A0F, 16'h0000, 0, -1, -1, -1, -1);
    check("midframe_len",  m_len,  1);
    check("midframe_full", m_full, 0);

    // Asynchronous reset during the shift of a word.
    send_frame(16'h7777, 16'hFFFF, -1, -1, -1, -1, 5);
    check("post_rst_busy", m_busy, 0);
    pulse_start();
    send_frame(16'hC0DE, 16'hFFFF, 0, -1, -1, -1, -1);
    check("after_rst_len",  m_len,  1);
    check("after_rst_addr", m_addr, 1);

    // Stop the main instance, then fill the 8-word instance.
    slot(1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
    slot(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    check("main_stopped_busy", m_busy, 0);
    @(negedge clk); start_s = 1'b1;
    @(negedge clk); start_s = 1'b0;
    for (int i = 0; i < 9; i++)
      send_frame(16'h1000 + 16'(i), 16'hFFFF, -1, (i < 8) ? i : -1, -1, -1, -1);
    check("small_full", s_full, 1);
    check("small_busy", s_busy, 0);
    check("small_addr", s_addr, 7);

    repeat (4) slot(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    check("main_missing_strobes",  q_m.size(), 0);
    check("small_missing_strobes", q_s.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/aud_recorder.md
Name: aud_recorder

Overview:
- Capture stage directly downstream of the WM8731 codec, which is configured over I2C by the top-level init sequence.
- Deserialises 16-bit left-channel I2S samples from the codec ADC on the codec bit clock.
- Emits one write strobe per sample, with a linear address, to the SRAM write port.
- Controlled by the top-level record, pause and stop FSM.

Parameters:
DATA_W, 16, sample width in bits (matches codec 16-bit I2S setting)
ADDR_W, 20, SRAM word address width; capacity 2**ADDR_W samples

Ports:
i_clk  in  1  codec BCLK (i_aud_bclk); all logic on rising edge
i_rst_n  in  1  asynchronous active-low reset
i_start  in  1  level; begin recording (from IDLE) or resume (from PAUSE)
i_pause  in  1  level; pause after current sample completes
i_stop  in  1  level; abort immediately, return to IDLE
i_lrc  in  1  codec ADCLRCK; low = left channel
i_data  in  1  codec ADCDAT serial bit
o_address  out  ADDR_W  SRAM address of current/last write
o_data  out  DATA_W  captured sample, MSB first assembled
o_valid  out  1  one-cycle write strobe
o_length  out  ADDR_W  number of samples written this take
o_full  out  1  sticky: memory exhausted
o_busy  out  1  high in any state except S_IDLE

Behaviour:
- Reset values: all outputs 0; state S_IDLE; internal lrc_r=1, bit counter 0, shift register 0.
- lrc_r registers i_lrc every cycle. Falling edge at cycle t means i_lrc==0 && lrc_r==1.
- Command priority when asserted together: i_stop > i_pause > i_start.
- States:
  - S_IDLE: on i_start: o_address=0, o_length=0, o_full=0, go to S_WAIT_LEFT.
  - S_WAIT_LEFT: on falling edge at cycle t, go to S_SHIFT with counter=0.
  - S_SHIFT: sample i_data at edges t+1..t+16, MSB first (I2S one-bit delay). Shift left into a DATA_W register. After the 16th bit, go to S_STORE.
  - S_STORE (cycle t+17): o_valid=1 for exactly one cycle. o_data = shifted word. o_address = write address for that word.
    - Next cycle: o_length+=1.
    - If o_address == 2**ADDR_W-1: set o_full=1 and go to S_IDLE (address holds).
    - Otherwise o_address+=1 and go to S_WAIT_RIGHT.
  - S_WAIT_RIGHT: wait until i_lrc==1, then go to S_WAIT_LEFT. This guarantees exactly one capture per LRC frame.
  - S_PAUSE: o_address and o_length hold. On i_start (with no i_stop), go to S_WAIT_RIGHT.
- o_data holds its value between strobes.
- Pause: checked in S_WAIT_LEFT and S_WAIT_RIGHT only. In S_SHIFT or S_STORE the sample completes and is stored, then the block enters S_PAUSE.
- Stop: from any state, next cycle is S_IDLE.
  - A partial sample in S_SHIFT is discarded; no o_valid.
  - If in S_STORE, the strobe in that cycle still occurs; stop takes effect after it.
  - o_length and o_address hold for playback length.
- i_start in a non-IDLE, non-PAUSE state: ignored.
- Right-channel bits (i_lrc high): never captured.
- Reset mid-operation: immediate return to reset values. No strobe is generated.
- Width rules:
  - Counter is 5 bits and counts 0..15.
  - o_address and o_length do not wrap; the full condition stops capture first.

Decomposition:
- Shared package audio_pkg:
  - state enum (S_IDLE, S_WAIT_LEFT, S_SHIFT, S_STORE, S_WAIT_RIGHT, S_PAUSE)
  - DATA_W/ADDR_W defaults
  - I2S_DELAY=1 constant
- Optional sub-module i2s_deser: lrc edge detect plus 16-bit shifter, exposing word and word_done. The FSM and addressing stay in aud_recorder.

Test Plan:
- Reset then i_start, drive left words 16'hA5C3 and 16'h1234 (right words 16'hFFFF) → two o_valid pulses with o_data 16'hA5C3 @addr 0 and 16'h1234 @addr 1; each pulse at falling-edge cycle t+17; o_length=2.
- i_start with i_lrc already low mid-frame → no capture until the next full falling edge; first word is correct.
- i_pause asserted at bit 8 of word 3 → word 3 stored @addr 2, then no strobes.
  - i_start resumes → next word @addr 3.
- i_stop asserted at bit 10 → no strobe, S_IDLE next cycle, o_length unchanged, o_busy=0.
- ADDR_W=3, record 9 frames → exactly 8 strobes (addr 0..7), o_full=1 after 8th, o_busy=0, 9th frame ignored.
- i_rst_n pulsed low asynchronously mid-S_SHIFT → all outputs 0 immediately, no strobe; a later i_start records from addr 0.
